// File: rtl/branch_prediction_tracker.sv
// In-order tracker of issued branch predictions; pops on resolve and drives registered feedback one cycle later.
// o_full is combinational; pushes into a full tracker are dropped unless a pop frees a slot that same cycle.
module branch_prediction_tracker #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_req_pc,
  input  logic                  i_req_prediction,
  input  logic                  i_req_prediction1,
  input  logic                  i_req_prediction2,
  output logic                  o_full,
  input  logic                  i_res_valid,
  input  logic [ADDR_WIDTH-1:0] i_res_pc,
  input  logic                  i_res_outcome,
  input  logic                  i_flush,
  output logic                  o_fb_valid,
  output logic [ADDR_WIDTH-1:0] o_fb_pc,
  output logic                  o_fb_prediction,
  output logic                  o_fb_prediction1,
  output logic                  o_fb_prediction2,
  output logic                  o_fb_outcome,
  output logic                  o_mispredict,
  output logic                  o_err_overflow,
  output logic                  o_err_underflow,
  output logic                  o_err_pc,
  output logic [CNT_WIDTH-1:0]  o_branch_count,
  output logic [CNT_WIDTH-1:0]  o_mispredict_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic                  pred;
    logic                  pred1;
    logic                  pred2;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  entry_t           head;
  logic             pop, push, hit, miss_pc, is_misp;

  assign o_full  = (count == FULL_CNT);
  assign head    = mem[rd_ptr];
  assign pop     = i_res_valid && (count != '0);
  // A pop in the same cycle frees the head slot, so a full tracker can still accept.
  assign push    = i_req_valid && !i_flush && (!o_full || pop);
  assign hit     = pop && (head.pc == i_res_pc);
  assign miss_pc = pop && (head.pc != i_res_pc);
  assign is_misp = head.pred != i_res_outcome;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{pc: i_req_pc, pred: i_req_prediction,
                       pred1: i_req_prediction1, pred2: i_req_prediction2};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      // Flush overrides any same-cycle pop; the push is already suppressed.
      if (i_flush) begin
        count  <= '0;
        rd_ptr <= wr_ptr;
      end else begin
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + (PTR_W+1)'(1);
          2'b01:   count <= count - (PTR_W+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_fb_valid         <= 1'b0;
      o_fb_pc            <= '0;
      o_fb_prediction    <= 1'b0;
      o_fb_prediction1   <= 1'b0;
      o_fb_prediction2   <= 1'b0;
      o_fb_outcome       <= 1'b0;
      o_mispredict       <= 1'b0;
      o_err_overflow     <= 1'b0;
      o_err_underflow    <= 1'b0;
      o_err_pc           <= 1'b0;
      o_branch_count     <= '0;
      o_mispredict_count <= '0;
    end else begin
      o_fb_valid      <= hit;
      o_mispredict    <= hit && is_misp;
      o_err_pc        <= miss_pc;
      o_err_underflow <= i_res_valid && (count == '0);
      o_err_overflow  <= i_req_valid && !i_flush && o_full && !pop;
      // Data outputs hold their last feedback when nothing valid is emitted.
      if (hit) begin
        o_fb_pc          <= head.pc;
        o_fb_prediction  <= head.pred;
        o_fb_prediction1 <= head.pred1;
        o_fb_prediction2 <= head.pred2;
        o_fb_outcome     <= i_res_outcome;
        o_branch_count   <= o_branch_count + CNT_WIDTH'(1);
        if (is_misp) o_mispredict_count <= o_mispredict_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: doc/branch_prediction_tracker.md
Name: branch_prediction_tracker

Overview:
- Sits directly downstream of branch_predictor_combined.
- Captures every issued prediction (final, predictor-1, predictor-2) with its PC into an in-order FIFO at fetch.
- When the branch resolves in EX, pops the oldest entry and drives the registered feedback bundle (i_fb_*) back into the combined predictor and its sub-predictors.
- Also flags mispredicts and maintains branch and mispredict statistics counters.

Parameters:
- ADDR_WIDTH, 32, width of branch PC.
- DEPTH, 8, number of in-flight branches tracked; power of two, at least 2.
- CNT_WIDTH, 32, width of statistics counters.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- i_req_valid  input  1  prediction issued this cycle
- i_req_pc  input  ADDR_WIDTH  PC of predicted branch
- i_req_prediction  input  1  final prediction (BranchOutcome: 0=NOT_TAKEN, 1=TAKEN)
- i_req_prediction1  input  1  local predictor output
- i_req_prediction2  input  1  global predictor output
- o_full  output  1  tracker full; fetch must stall branch issue
- i_res_valid  input  1  branch resolved this cycle
- i_res_pc  input  ADDR_WIDTH  PC of resolved branch
- i_res_outcome  input  1  actual outcome
- i_flush  input  1  pipeline redirect; squash all unresolved entries
- o_fb_valid  output  1  feedback valid
- o_fb_pc  output  ADDR_WIDTH  feedback PC
- o_fb_prediction  output  1  stored final prediction
- o_fb_prediction1  output  1  stored predictor-1 prediction
- o_fb_prediction2  output  1  stored predictor-2 prediction
- o_fb_outcome  output  1  resolved outcome
- o_mispredict  output  1  high with o_fb_valid when prediction != outcome
- o_err_overflow  output  1  one-cycle pulse: push dropped
- o_err_underflow  output  1  one-cycle pulse: resolve with empty tracker
- o_err_pc  output  1  one-cycle pulse: resolved PC != head PC
- o_branch_count  output  CNT_WIDTH  feedbacks emitted
- o_mispredict_count  output  CNT_WIDTH  mispredicts emitted

Behaviour:
- Reset:
  - Read/write pointers and occupancy count = 0.
  - All o_fb_* = 0; o_mispredict = 0; all o_err_* = 0.
  - Both statistics counters = 0.
  - o_full = 0.
- Storage: circular FIFO of DEPTH entries {pc, pred, pred1, pred2}. Pointers are log2(DEPTH) bits and wrap naturally. Occupancy count is log2(DEPTH)+1 bits.
- o_full is combinational: count == DEPTH.
- Pop: occurs when i_res_valid && count > 0.
  - The head entry is read and compared against i_res_pc.
- Feedback timing: one-cycle latency. All o_fb_* and o_mispredict are registered in the cycle after the pop.
  - o_fb_valid is high for exactly one cycle per pop, and only when the PC matches.
  - On PC mismatch: the entry is still popped, o_fb_valid stays 0, and o_err_pc pulses next cycle.
  - When o_fb_valid = 0, the data outputs hold their last values.
- Underflow: i_res_valid with count == 0 → no pop, no feedback, o_err_underflow pulses next cycle.
- Push: occurs when i_req_valid && !i_flush && (count < DEPTH || pop this cycle).
  - Writes at the write pointer.
  - Push into a full FIFO with a same-cycle pop is allowed; count is unchanged.
- Overflow: i_req_valid when full with no pop → push dropped, state unchanged, o_err_overflow pulses next cycle.
- Simultaneous push and pop with count == 0: the pop is an underflow; the push is accepted. Bypass from write to pop is not allowed.
- Flush:
  - Any pop in the same cycle completes first and its feedback is emitted normally.
  - Then all entries are discarded: count = 0, read pointer = write pointer.
  - A push in the flush cycle is dropped silently; no overflow error is raised.
- Counters are registered with o_fb_valid:
  - o_branch_count += 1 on each emitted feedback.
  - o_mispredict_count += 1 when o_mispredict is also asserted.
  - Both wrap modulo 2^CNT_WIDTH.
- Reset asserted mid-operation: everything returns to reset values on the next clock edge; no feedback is emitted for pending entries.

Test Plan:
- Push PC 0x100 (pred=1, p1=1, p2=0), then resolve 0x100 outcome 0 → one cycle later: o_fb_valid=1, pc 0x100, prediction=1, p1=1, p2=0, outcome=0, o_mispredict=1; o_branch_count=1, o_mispredict_count=1.
- Push 8 branches 0x00..0x1C with no resolves → o_full=1 after the 8th. Ninth push → o_err_overflow pulse, count stays 8. Resolve all 8 in order → feedback PCs appear in order 0x00..0x1C.
- Tracker full; push 0x200 and resolve 0x00 in the same cycle → both accepted, o_full stays 1. The 8th subsequent resolve returns 0x200.
- Push 0x10, 0x14, 0x18; resolve 0x10 with i_flush=1 and push 0x1C in the same cycle → feedback emitted for 0x10, count=0, 0x1C dropped. Next resolve → o_err_underflow.
- Push 0x40; resolve 0x44 → o_err_pc pulse, o_fb_valid=0, counters unchanged, tracker empty.
- Force o_branch_count to 2^CNT_WIDTH−1 (CNT_WIDTH=4 build: 15); one more feedback → count wraps to 0. Assert rst_n=0 with 3 entries pending → all outputs 0, o_full=0, no feedback follows.
